// File: rtl/rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types, constants and small helpers for the three-way round-robin
// arbiter (rr_arbiter) and its pick logic (rr_pick).
//   arb_state_t : arbiter FSM states (ARB_IDLE, ARB_GRANT)
//   arb_id_t    : 2-bit encoded requester ID, 0 = none, 1..3 = requester
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int NUM_REQ = 3;

    typedef logic [1:0] arb_id_t;

    localparam arb_id_t ID_NONE = 2'd0;
    localparam arb_id_t ID_R1   = 2'd1;
    localparam arb_id_t ID_R2   = 2'd2;
    localparam arb_id_t ID_R3   = 2'd3;

    // One-hot request/grant bit for an ID; ID_NONE maps to no bit.
    function automatic logic [NUM_REQ-1:0] id2onehot(arb_id_t id);
        case (id)
            ID_R1:   return 3'b001;
            ID_R2:   return 3'b010;
            ID_R3:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Next ID in the circular order 1 -> 2 -> 3 -> 1 (ID_NONE steps to 1).
    function automatic arb_id_t rr_next(arb_id_t id);
        return (id == ID_R3) ? ID_R1 : arb_id_t'(id + 2'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter_if
// Request/grant bundle between three requesters and rr_arbiter.
//   r1..r3 : requests (requester -> arbiter)
//   g1..g3 : registered grants (arbiter -> requester)
//   gnt_id : encoded holder, 0 none, 1..3 requester number
//   busy   : high while any grant is active
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rr_arbiter_if;
    import arb_pkg::*;

    logic    r1;
    logic    r2;
    logic    r3;
    logic    g1;
    logic    g2;
    logic    g3;
    arb_id_t gnt_id;
    logic    busy;

    modport master (
        output r1, r2, r3,
        input  g1, g2, g3, gnt_id, busy
    );

    modport slave (
        input  r1, r2, r3,
        output g1, g2, g3, gnt_id, busy
    );

endinterface

// File: rtl/rr_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches last+1, last+2, last+3
// (circular over 1..3) and returns the first requester that is active and
// not excluded.
//   i_req   : request vector, bit0 = requester 1
//   i_last  : ID of the most recent winner (search starts after it)
//   i_excl  : mask of requesters that may not win this time
//   o_id    : winner ID, ID_NONE when nobody qualifies
//   o_valid : a winner was found
// ---------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  arb_id_t            i_last,
    input  logic [NUM_REQ-1:0] i_excl,
    output arb_id_t            o_id,
    output logic               o_valid
);

    logic [NUM_REQ-1:0] w_masked;
    arb_id_t            w_cand;

    assign w_masked = i_req & ~i_excl;

    always_comb begin
        o_id    = ID_NONE;
        o_valid = 1'b0;
        w_cand  = i_last;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = rr_next(w_cand);
            if (!o_valid && ((id2onehot(w_cand) & w_masked) != '0)) begin
                o_id    = w_cand;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Clocked round-robin arbiter for three requesters. A grant is held while
// the winner keeps requesting; when it drops, the next active requester in
// round-robin order is granted on the same edge (no idle gap).
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_arbiter_if.slave (r1..r3 in; g1..g3, gnt_id, busy out)
// Parameter MAX_HOLD (2..255): grant-cycle limit used with the timeout.
// Build option ARB_TIMEOUT_EN: when defined, a holder that has held the
// grant for MAX_HOLD cycles is forced off if another requester is waiting.
// ---------------------------------------------------------------------------
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter_if.slave   bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter: MAX_HOLD must be in 2..255");
    end

    arb_state_t         r_state;
    arb_id_t            r_last;
    logic [NUM_REQ-1:0] r_gnt;
    arb_id_t            r_gnt_id;
    logic               r_busy;

    arb_state_t         w_nxt_state;
    arb_id_t            w_nxt_last;
    logic [NUM_REQ-1:0] w_nxt_gnt;
    arb_id_t            w_nxt_id;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_excl;
    logic               w_holder_req;
    arb_id_t            w_pick_id;
    logic               w_pick_vld;
    logic               w_timeout;

    assign w_req = {bus.r3, bus.r2, bus.r1};

    // While granting, r_last is the holder; keep it out of the search so a
    // handoff (or forced release) always moves to a different requester.
    assign w_excl       = (r_state == ARB_GRANT) ? id2onehot(r_last) : '0;
    assign w_holder_req = |(w_req & id2onehot(r_last));

    rr_pick u_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .i_excl  (w_excl),
        .o_id    (w_pick_id),
        .o_valid (w_pick_vld)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    logic [7:0] r_hold_cnt;
    logic       w_new_grant;

    // A new grant always changes the winner, except when coming from idle.
    assign w_new_grant = (w_nxt_state == ARB_GRANT) &&
                         ((r_state == ARB_IDLE) || (w_nxt_last != r_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (w_nxt_state == ARB_IDLE) begin
            r_hold_cnt <= '0;
        end else if (w_new_grant) begin
            r_hold_cnt <= 8'd1;
        end else if (r_hold_cnt != HOLD_MAX) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end

    // w_pick_vld already excludes the holder: it means "someone else waits".
    assign w_timeout = (r_hold_cnt == HOLD_MAX) && w_pick_vld;
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_last  = r_last;
        w_nxt_gnt   = r_gnt;
        w_nxt_id    = r_gnt_id;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_vld) begin
                    w_nxt_state = ARB_GRANT;
                    w_nxt_last  = w_pick_id;
                    w_nxt_gnt   = id2onehot(w_pick_id);
                    w_nxt_id    = w_pick_id;
                end
            end
            ARB_GRANT: begin
                if (w_holder_req && !w_timeout) begin
                    w_nxt_state = ARB_GRANT;
                end else if (w_pick_vld) begin
                    w_nxt_state = ARB_GRANT;
                    w_nxt_last  = w_pick_id;
                    w_nxt_gnt   = id2onehot(w_pick_id);
                    w_nxt_id    = w_pick_id;
                end else begin
                    w_nxt_state = ARB_IDLE;
                    w_nxt_gnt   = '0;
                    w_nxt_id    = ID_NONE;
                end
            end
            default: begin
                w_nxt_state = ARB_IDLE;
                w_nxt_gnt   = '0;
                w_nxt_id    = ID_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ARB_IDLE;
            r_last   <= ID_R3;
            r_gnt    <= '0;
            r_gnt_id <= ID_NONE;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_last   <= w_nxt_last;
            r_gnt    <= w_nxt_gnt;
            r_gnt_id <= w_nxt_id;
            r_busy   <= |w_nxt_gnt;
        end
    end

    assign bus.g1     = r_gnt[0];
    assign bus.g2     = r_gnt[1];
    assign bus.g3     = r_gnt[2];
    assign bus.gnt_id = r_gnt_id;
    assign bus.busy   = r_busy;

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
Clocked round-robin arbiter for three requesters sharing one resource. It is the sequential successor to the team's combinational fixed-priority arbiter and keeps the same r1..r3 / g1..g3 port names. A grant is held for as long as the winner keeps requesting, and grants rotate fairly between requesters. It also outputs an encoded grant ID using the bench's "truth" encoding: 0 = none, 1..3 = requester number.

Parameters:
MAX_HOLD, 8, maximum consecutive grant cycles before a forced release (used only when ARB_TIMEOUT_EN is defined); legal range 2..255.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous, active-low reset
r1  input  1  request from requester 1
r2  input  1  request from requester 2
r3  input  1  request from requester 3
g1  output  1  grant to requester 1 (registered)
g2  output  1  grant to requester 2 (registered)
g3  output  1  grant to requester 3 (registered)
gnt_id  output  2  encoded holder: 0 none, 1/2/3 = g1/g2/g3
busy  output  1  high while any grant is active

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (asserts immediately, no clock needed): g1=g2=g3=0, gnt_id=0, busy=0, state=ARB_IDLE, last=3, hold_cnt=0.
- Because last resets to 3, requester 1 has highest priority on the first arbitration.
- All outputs are registered. At most one of g1..g3 is high in any cycle. gnt_id and busy are consistent with g1..g3 in every cycle.
- Round-robin pick: search order is last+1, last+2, last+3 (mod 3, values 1..3). The first requester found active wins.
- ARB_IDLE:
  - If any r is high at an edge, the winner's g rises at that same edge (grant seen one cycle after the request is sampled).
  - On that edge: last <= winner, hold_cnt <= 1, state <= ARB_GRANT.
- ARB_GRANT, holder's r still high: grant held; hold_cnt increments and saturates at MAX_HOLD.
- ARB_GRANT, holder's r low at an edge:
  - The holder's g falls at that edge.
  - In the same edge, re-arbitrate among the other requesters currently high (back-to-back handoff, no idle gap). The new winner's g rises, last updates and hold_cnt <= 1.
  - If no other requester is high, go to ARB_IDLE with all g low.
- Requests dropping and rising in the same cycle: only the values sampled at the edge matter. No pulse capture and no queuing.
- A request from the current holder that drops for one sampled cycle always releases the grant.
- Reset asserted mid-grant: grant is removed asynchronously and the pointer returns to last=3.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined: if hold_cnt == MAX_HOLD at an edge and at least one other requester is high, the grant is forcibly passed to the next round-robin requester, even though the holder still requests.
- Defined, no other requester high: the holder keeps the grant and hold_cnt stays saturated.
- Not defined: no forced release. The grant is held indefinitely while the holder requests. hold_cnt logic may be optimised away.

Decomposition:
- Package arb_pkg holds:
  - state enum arb_state_t {ARB_IDLE, ARB_GRANT}
  - constants NUM_REQ=3 and ID_NONE=0, ID_R1=1, ID_R2=2, ID_R3=3
  - 2-bit type arb_id_t
- One combinational sub-module, rr_pick:
  - inputs: 3-bit request vector, last ID, 3-bit exclude mask
  - outputs: winner ID (0 if none) and valid
- rr_arbiter instantiates rr_pick once and contains the FSM, hold counter and output registers.

Test Plan:
1. Reset check: hold rst_n=0 with r1=r2=r3=1 -> g1..g3=0, gnt_id=0, busy=0. Release reset -> next edge gives g1=1, gnt_id=1.
2. Single requester: r2=1 alone for 5 cycles, then 0 -> g2 high from the edge after r2 is sampled until the edge after r2 falls. gnt_id=2 throughout, then 0.
3. Rotation: r1=r2=r3=1 held, with each holder dropping its request for one cycle after 2 granted cycles -> grant order 1,2,3,1. No cycle with two grants. Handoff has no idle cycle.
4. Fairness after a win: r3 granted and released, then r1 and r3 raised together -> g1 wins (last=3, so order is 1,2,3).
5. Mid-operation reset: g2 held and rst_n pulsed low between edges -> g2 drops immediately, without waiting for a clock. After reset with r2=r3=1 -> g2 is granted (last=3, and r1 is not requesting).
6. ARB_TIMEOUT_EN defined, MAX_HOLD=4: r1 held high with r2=1 -> g1 for 4 cycles, then g2. With r2=0 instead -> g1 held indefinitely. Macro undefined -> g1 held indefinitely in both cases.
